// File: rtl/rpg_gen_pkg.sv
// Shared encodings and constants for the rpg_gen reference pattern generator.
package rpg_pkg;

    localparam logic [1:0] MODE_CHK = 2'b00;
    localparam logic [1:0] MODE_ONE = 2'b01;
    localparam logic [1:0] MODE_P7  = 2'b10;
    localparam logic [1:0] MODE_P15 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_MARK,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam int LFSR_MAX_W = 15;

    localparam int P7_W     = 7;
    localparam int P7_TAP_A = 6;
    localparam int P7_TAP_B = 5;
    localparam logic [LFSR_MAX_W-1:0] P7_SEED = 15'h007F;

    localparam int P15_W     = 15;
    localparam int P15_TAP_A = 14;
    localparam int P15_TAP_B = 13;
    localparam logic [LFSR_MAX_W-1:0] P15_SEED = 15'h7FFF;

    localparam int DLY_DEPTH = 16;

endpackage

// File: rtl/rpg_gen_if.sv
// Control/status bundle between the pattern generator and its host.
// INJ exists only when RPG_ERR_INJECT_EN is defined.
interface rpg_gen_if #(
    parameter int CNT_W = 32
);
    logic             START;
    logic             STOP;
    logic [1:0]       MODE;
    logic [3:0]       LAT_SEL;
    logic             PAT_OUT;
    logic             RPG_OUT;
    logic             BUSY;
    logic             IN_RUN;
    logic [CNT_W-1:0] RUN_CNT;
`ifdef RPG_ERR_INJECT_EN
    logic             INJ;

    modport master (
        output START, STOP, MODE, LAT_SEL, INJ,
        input  PAT_OUT, RPG_OUT, BUSY, IN_RUN, RUN_CNT
    );

    modport slave (
        input  START, STOP, MODE, LAT_SEL, INJ,
        output PAT_OUT, RPG_OUT, BUSY, IN_RUN, RUN_CNT
    );
`else
    modport master (
        output START, STOP, MODE, LAT_SEL,
        input  PAT_OUT, RPG_OUT, BUSY, IN_RUN, RUN_CNT
    );

    modport slave (
        input  START, STOP, MODE, LAT_SEL,
        output PAT_OUT, RPG_OUT, BUSY, IN_RUN, RUN_CNT
    );
`endif
endinterface

// File: rtl/rpg_gen_lfsr.sv
// Fibonacci LFSR of configurable width (up to 15) with a single XOR tap pair.
// Output is the MSB of the active width; the next state shifts the feedback into bit 0.
module rpg_lfsr
    import rpg_pkg::*;
#(
    parameter int                      W     = 7,
    parameter int                      TAP_A = 6,
    parameter int                      TAP_B = 5,
    parameter logic [LFSR_MAX_W-1:0]   SEED  = 15'h007F
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    input  logic adv,
    output logic bit_out
);

    localparam logic [LFSR_MAX_W-1:0] MASK = LFSR_MAX_W'((1 << W) - 1);

    logic [LFSR_MAX_W-1:0] sr;
    logic                  fb;
    logic                  unused_msb;

    assign fb         = sr[TAP_A] ^ sr[TAP_B];
    assign bit_out    = sr[W-1];
    assign unused_msb = sr[LFSR_MAX_W-1];

    // Bits above the active width are masked so they never feed back.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr <= SEED;
        end else if (load) begin
            sr <= SEED;
        end else if (adv) begin
            sr <= {sr[LFSR_MAX_W-2:0], fb} & MASK;
        end
    end

endmodule

// File: rtl/rpg_gen.sv
// Reference pattern generator: zero flush, one-cycle marker, then the selected pattern,
// with a latency-matched reference copy on RPG_OUT. Optional macro: RPG_ERR_INJECT_EN.
module rpg_gen
    import rpg_pkg::*;
#(
    parameter int FLUSH_LEN = 32,
    parameter int DRAIN_LEN = 16,
    parameter int CNT_W     = 32
) (
    input logic      CLK,
    input logic      RST,
    rpg_gen_if.slave bus
);

    state_t               state;
    state_t               nstate;
    logic [31:0]          cnt;
    logic [31:0]          cnt_nxt;
    logic [1:0]           mode_q;
    logic [3:0]           lat_q;
    logic                 chk_q;
    logic                 pat_q;
    logic                 pat_nxt;
    logic                 pat_bit;
    logic                 rpg_q;
    logic                 busy_q;
    logic                 run_q;
    logic                 start_ok;
    logic                 lfsr_adv;
    logic [CNT_W-1:0]     run_cnt;
    logic [DLY_DEPTH-2:0] dly;
    logic [DLY_DEPTH-1:0] taps;
    logic                 p7_bit;
    logic                 p15_bit;
    logic                 flip;

    rpg_lfsr #(
        .W     (P7_W),
        .TAP_A (P7_TAP_A),
        .TAP_B (P7_TAP_B),
        .SEED  (P7_SEED)
    ) u_p7 (
        .CLK     (CLK),
        .RST     (RST),
        .load    (start_ok),
        .adv     (lfsr_adv),
        .bit_out (p7_bit)
    );

    rpg_lfsr #(
        .W     (P15_W),
        .TAP_A (P15_TAP_A),
        .TAP_B (P15_TAP_B),
        .SEED  (P15_SEED)
    ) u_p15 (
        .CLK     (CLK),
        .RST     (RST),
        .load    (start_ok),
        .adv     (lfsr_adv),
        .bit_out (p15_bit)
    );

    always_comb begin
        nstate   = state;
        start_ok = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.START && !bus.STOP) begin
                    nstate   = ST_FLUSH;
                    start_ok = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (bus.STOP) begin
                    nstate = ST_DRAIN;
                end else if (cnt == 32'(FLUSH_LEN - 1)) begin
                    nstate = ST_MARK;
                end
            end
            ST_MARK: begin
                nstate = bus.STOP ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (bus.STOP) begin
                    nstate = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt == 32'(DRAIN_LEN - 1)) begin
                    nstate = ST_IDLE;
                end
            end
            default: begin
                nstate = ST_IDLE;
            end
        endcase

        // The phase counter only runs while staying in a timed state.
        if ((state == ST_FLUSH || state == ST_DRAIN) && nstate == state) begin
            cnt_nxt = cnt + 32'd1;
        end else begin
            cnt_nxt = '0;
        end
    end

    always_comb begin
        pat_bit = chk_q;
        case (mode_q)
            MODE_ONE: pat_bit = 1'b1;
            MODE_P7:  pat_bit = p7_bit;
            MODE_P15: pat_bit = p15_bit;
            default:  pat_bit = chk_q;
        endcase

        // PAT_OUT is decided by the state being entered (or held) on this edge.
        pat_nxt = 1'b0;
        if (nstate == ST_MARK) begin
            pat_nxt = 1'b1;
        end else if (nstate == ST_RUN) begin
            pat_nxt = pat_bit;
        end
    end

    // Each RUN bit consumes one LFSR step, including the first one taken from the seed.
    assign lfsr_adv = (nstate == ST_RUN);
    assign taps     = {dly, pat_q};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            mode_q  <= MODE_CHK;
            lat_q   <= '0;
            chk_q   <= 1'b0;
            pat_q   <= 1'b0;
            busy_q  <= 1'b0;
            run_q   <= 1'b0;
            run_cnt <= '0;
            dly     <= '0;
            rpg_q   <= 1'b0;
        end else begin
            state  <= nstate;
            cnt    <= cnt_nxt;
            pat_q  <= pat_nxt;
            busy_q <= (nstate != ST_IDLE);
            run_q  <= (nstate == ST_RUN);
            dly    <= {dly[DLY_DEPTH-3:0], pat_q};
            rpg_q  <= taps[lat_q] ^ flip;
            if (start_ok) begin
                mode_q  <= bus.MODE;
                lat_q   <= bus.LAT_SEL;
                chk_q   <= 1'b0;
                run_cnt <= '0;
            end else begin
                if (nstate == ST_RUN) begin
                    chk_q <= ~chk_q;
                end
                if (state == ST_RUN && run_cnt != '1) begin
                    run_cnt <= run_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef RPG_ERR_INJECT_EN
    logic flip_q;

    // A pending flip blocks further requests until it has been applied.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flip_q <= 1'b0;
        end else begin
            flip_q <= bus.INJ && run_q && !flip_q;
        end
    end

    assign flip = flip_q;
`else
    assign flip = 1'b0;
`endif

    assign bus.PAT_OUT = pat_q;
    assign bus.RPG_OUT = rpg_q;
    assign bus.BUSY    = busy_q;
    assign bus.IN_RUN  = run_q;
    assign bus.RUN_CNT = run_cnt;

endmodule

// File: tb/tb_rpg_gen.sv
// Directed bench for rpg_gen: flush/marker timing, patterns, latency, drain, reset and injection.
module tb_rpg_gen;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    rpg_gen_if #(.CNT_W(32)) bus ();

    rpg_gen #(
        .FLUSH_LEN (32),
        .DRAIN_LEN (16),
        .CNT_W     (32)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int   nvec    = 0;
    int   nerr    = 0;
    int   exp_lag = 0;
    bit   lag_on  = 1'b0;
    int   ndiff   = 0;
    logic hist [0:15];
    logic bits [0:65533];
    logic [13:0] p7_ref;
    logic [14:0] m15;
    int   zrun;
    int   zmax;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Advance one clock; history holds PAT_OUT as seen before each edge.
    task automatic step();
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = bus.PAT_OUT;
        @(posedge CLK);
        #1;
        if (lag_on) chk1("lag", bus.RPG_OUT, hist[exp_lag]);
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic step_cnt();
        step();
        if (bus.RPG_OUT !== hist[exp_lag]) ndiff++;
    endtask

    task automatic start_run(input logic [1:0] mode, input logic [3:0] lat);
        bus.MODE    = mode;
        bus.LAT_SEL = lat;
        bus.START   = 1'b1;
        step();
        bus.START   = 1'b0;
    endtask

    task automatic stop_and_drain();
        bus.STOP = 1'b1;
        step();
        bus.STOP = 1'b0;
        run_steps(16);
        chk1("drain_done_busy", bus.BUSY, 1'b0);
    endtask

    initial begin
        bus.START   = 1'b0;
        bus.STOP    = 1'b0;
        bus.MODE    = 2'b00;
        bus.LAT_SEL = 4'd0;
`ifdef RPG_ERR_INJECT_EN
        bus.INJ     = 1'b0;
`endif
        for (int k = 0; k < 16; k++) hist[k] = 1'b0;
        p7_ref = 14'b11111110000001;

        // Reset values
        #12;
        chk1("rst_pat", bus.PAT_OUT, 1'b0);
        chk1("rst_rpg", bus.RPG_OUT, 1'b0);
        chk1("rst_busy", bus.BUSY, 1'b0);
        chk1("rst_inrun", bus.IN_RUN, 1'b0);
        chkw("rst_runcnt", bus.RUN_CNT, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        step();
        lag_on = 1'b1;

        // PRBS7, LAT_SEL=0: flush, marker, first bits, STOP after 100 RUN cycles
        start_run(2'b10, 4'd0);
        chk1("start_busy", bus.BUSY, 1'b1);
        chk1("flush_inrun", bus.IN_RUN, 1'b0);
        for (int i = 0; i < 32; i++) begin
            chk1("flush_pat", bus.PAT_OUT, 1'b0);
            step();
        end
        chk1("marker_pat", bus.PAT_OUT, 1'b1);
        chk1("marker_inrun", bus.IN_RUN, 1'b0);
        step();
        chk1("run_inrun", bus.IN_RUN, 1'b1);
        for (int i = 0; i < 14; i++) begin
            chk1("p7_bit", bus.PAT_OUT, p7_ref[13-i]);
            step();
        end
        chkw("runcnt_14", bus.RUN_CNT, 32'd14);
        run_steps(85);
        bus.STOP = 1'b1;
        step();
        bus.STOP = 1'b0;
        chkw("runcnt_100", bus.RUN_CNT, 32'd100);
        chk1("drain_inrun", bus.IN_RUN, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk1("drain_pat", bus.PAT_OUT, 1'b0);
            chk1("drain_busy", bus.BUSY, 1'b1);
            step();
        end
        chk1("idle_busy", bus.BUSY, 1'b0);
        chk1("idle_rpg", bus.RPG_OUT, 1'b0);
        chkw("idle_runcnt_hold", bus.RUN_CNT, 32'd100);

        // START with STOP in IDLE: STOP wins
        bus.START = 1'b1;
        bus.STOP  = 1'b1;
        step();
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        chk1("startstop_busy", bus.BUSY, 1'b0);
        step();
        chk1("startstop_busy2", bus.BUSY, 1'b0);
        chkw("startstop_runcnt", bus.RUN_CNT, 32'd100);

        // Checkerboard, LAT_SEL=9; MODE/LAT_SEL changed mid-RUN must not matter
        exp_lag = 9;
        start_run(2'b00, 4'd9);
        run_steps(32);
        chk1("l9_marker_pat", bus.PAT_OUT, 1'b1);
        for (int j = 1; j <= 40; j++) begin
            if (j == 6) begin
                bus.LAT_SEL = 4'd3;
                bus.MODE    = 2'b01;
            end
            step();
            chk1("chk_bit", bus.PAT_OUT, logic'((j - 1) % 2));
            if (j < 10) chk1("l9_rpg_pre", bus.RPG_OUT, 1'b0);
            if (j == 10) chk1("l9_rpg_marker", bus.RPG_OUT, 1'b1);
        end
        stop_and_drain();

        // PRBS15 over two periods, with MODE/LAT_SEL disturbed mid-RUN
        exp_lag = 0;
        start_run(2'b11, 4'd0);
        run_steps(32);
        chk1("p15_marker", bus.PAT_OUT, 1'b1);
        step();
        m15 = 15'h7FFF;
        for (int i = 0; i < 65534; i++) begin
            if (i == 1000) begin
                bus.MODE    = 2'b00;
                bus.LAT_SEL = 4'd7;
            end
            chk1("p15_bit", bus.PAT_OUT, m15[14]);
            bits[i] = bus.PAT_OUT;
            m15 = {m15[13:0], m15[14] ^ m15[13]};
            step();
        end
        zrun = 0;
        zmax = 0;
        for (int i = 0; i < 32767; i++) begin
            chk1("p15_period", bits[i + 32767], bits[i]);
        end
        for (int i = 0; i < 65534; i++) begin
            zrun = (bits[i] == 1'b0) ? zrun + 1 : 0;
            if (zrun > zmax) zmax = zrun;
        end
        chk1("p15_nonzero", logic'(zmax < 15), 1'b1);
        stop_and_drain();

        // Asynchronous reset mid-RUN, then restart with a reseeded LFSR
        start_run(2'b01, 4'd0);
        run_steps(40);
        chk1("pre_rst_pat", bus.PAT_OUT, 1'b1);
        chk1("pre_rst_inrun", bus.IN_RUN, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        chk1("arst_pat", bus.PAT_OUT, 1'b0);
        chk1("arst_rpg", bus.RPG_OUT, 1'b0);
        chk1("arst_busy", bus.BUSY, 1'b0);
        chk1("arst_inrun", bus.IN_RUN, 1'b0);
        chkw("arst_runcnt", bus.RUN_CNT, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 16; k++) hist[k] = 1'b0;
        start_run(2'b10, 4'd0);
        chk1("restart_busy", bus.BUSY, 1'b1);
        chk1("restart_pat", bus.PAT_OUT, 1'b0);
        run_steps(32);
        chk1("restart_marker", bus.PAT_OUT, 1'b1);
        step();
        for (int i = 0; i < 14; i++) begin
            chk1("restart_p7", bus.PAT_OUT, p7_ref[13-i]);
            step();
        end
        chkw("restart_runcnt", bus.RUN_CNT, 32'd14);
        stop_and_drain();

`ifdef RPG_ERR_INJECT_EN
        // Error injection on checkerboard, LAT_SEL=2
        exp_lag = 2;
        lag_on  = 1'b0;
        ndiff   = 0;
        start_run(2'b00, 4'd2);
        bus.INJ = 1'b1;
        step_cnt();
        bus.INJ = 1'b0;
        for (int i = 0; i < 40; i++) step_cnt();
        chkw("inj_outside_run", ndiff, 32'd0);
        ndiff   = 0;
        bus.INJ = 1'b1;
        step_cnt();
        step_cnt();
        bus.INJ = 1'b0;
        for (int i = 0; i < 20; i++) step_cnt();
        chkw("inj_double_pulse", ndiff, 32'd1);
        ndiff   = 0;
        bus.INJ = 1'b1;
        step_cnt();
        bus.INJ = 1'b0;
        for (int i = 0; i < 20; i++) step_cnt();
        chkw("inj_single_pulse", ndiff, 32'd1);
        lag_on = 1'b1;
        stop_and_drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
